caq_tape_player: RTL and testbench

//  Plays a CAQ cassette image held in tape RAM as the 1-bit cassette input waveform (cass_in) seen by the PLA.

---
 rtl/caq_pkg.sv | 16 +
 rtl/caq_tape_player_if.sv | 9 +
 rtl/caq_bit_encoder.sv | 52 +++++
 rtl/caq_tape_player.sv | 168 ++++++++++++++++
 tb/tb_caq_tape_player.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/caq_pkg.sv
// Shared types and constants for the CAQ cassette player.
// Bit timing is expressed in ce_tape ticks per half-cycle of the waveform.
package caq_pkg;

    typedef enum logic [1:0] {IDLE, LEADER, BYTE, TAIL} caq_state_t;

    localparam int FRAME_BITS = 11;
    localparam int TICKS_ONE  = 1;
    localparam int TICKS_ZERO = 2;

    // Reload value for the half-cycle down-counter.
    function automatic logic [1:0] half_ticks(input logic bit_val);
        return bit_val ? 2'(TICKS_ONE - 1) : 2'(TICKS_ZERO - 1);
    endfunction

endpackage

// File: rtl/caq_tape_player_if.sv
// Tape RAM read port: the player drives the address; the RAM returns a byte
// one clock later.
interface caq_tape_player_if #(parameter int AW = 16);
    logic [AW-1:0] addr;
    logic [7:0]    data;

    modport master (output addr, input data);
    modport slave  (input addr, output data);
endinterface

// File: rtl/caq_bit_encoder.sv
// Turns one bit into a high half followed by a low half, each lasting
// TICKS_ONE or TICKS_ZERO ce_tape ticks. done fires on the tick that ends the low half.
module caq_bit_encoder import caq_pkg::*; (
    input  logic clk,
    input  logic reset,
    input  logic ce_tape,
    input  logic clear,
    input  logic start,
    input  logic bit_val,
    output logic level,
    output logic busy,
    output logic done
);

    logic       bit_q;
    logic       high_half;
    logic [1:0] tick_cnt;

    assign done = ce_tape & ~clear & busy & ~high_half & (tick_cnt == 2'd0);

    // clear drops the current bit but leaves level alone, so level only moves on ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level     <= 1'b0;
            busy      <= 1'b0;
            bit_q     <= 1'b0;
            high_half <= 1'b0;
            tick_cnt  <= 2'd0;
        end else if (clear) begin
            busy <= 1'b0;
        end else if (ce_tape) begin
            if (start) begin
                busy      <= 1'b1;
                bit_q     <= bit_val;
                high_half <= 1'b1;
                level     <= 1'b1;
                tick_cnt  <= half_ticks(bit_val);
            end else if (busy) begin
                if (tick_cnt != 2'd0) begin
                    tick_cnt <= tick_cnt - 2'd1;
                end else if (high_half) begin
                    high_half <= 1'b0;
                    level     <= 1'b0;
                    tick_cnt  <= half_ticks(bit_q);
                end else begin
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/caq_tape_player.sv
// Plays a CAQ tape image from RAM as the serial cassette level.
//   state  | meaning
//   IDLE   | no playback, out low, req low
//   LEADER | emitting LEADER_BITS '1' bits
//   BYTE   | shifting 11-bit frames (start 0, data MSB first, two stop 1s)
//   TAIL   | emitting TAIL_BITS '1' bits, then back to IDLE
module caq_tape_player import caq_pkg::*; #(
    parameter int AW          = 16,
    parameter int LEADER_BITS = 256,
    parameter int TAIL_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce_tape,
    input  logic                  loaded,
    input  logic [AW-1:0]         length,
    caq_tape_player_if.master     ram,
    output logic                  req,
    output logic                  out
);

    localparam int RUN_MAX = (LEADER_BITS > TAIL_BITS) ? LEADER_BITS : TAIL_BITS;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    caq_state_t     state, state_nx;
    logic [RUN_W-1:0] run_cnt, run_nx;
    logic [3:0]     bit_cnt, bit_nx;
    logic [9:0]     frame_sr, frame_nx;
    logic [AW-1:0]  bytes_sent, sent_nx;
    logic [AW-1:0]  len_q;
    logic [7:0]     hold;
    logic           hold_valid;
    logic [1:0]     fetch_pipe;
    logic           inc_pend;
    logic           restart, bnd, frame_start, consume;
    logic           enc_start, enc_bit, enc_busy, enc_done;

    assign restart = loaded & (length != '0);
    assign bnd     = ce_tape & ~restart & (~enc_busy | enc_done);
    assign req     = (state != IDLE);

    caq_bit_encoder u_enc (
        .clk     (clk),
        .reset   (reset),
        .ce_tape (ce_tape),
        .clear   (restart),
        .start   (enc_start),
        .bit_val (enc_bit),
        .level   (out),
        .busy    (enc_busy),
        .done    (enc_done)
    );

    always_comb begin
        state_nx    = state;
        run_nx      = run_cnt;
        bit_nx      = bit_cnt;
        frame_nx    = frame_sr;
        sent_nx     = bytes_sent;
        enc_start   = 1'b0;
        enc_bit     = 1'b1;
        frame_start = 1'b0;
        consume     = 1'b0;
        if (restart) begin
            state_nx = LEADER;
            run_nx   = RUN_W'(LEADER_BITS);
            bit_nx   = 4'd0;
            frame_nx = 10'd0;
            sent_nx  = '0;
        end else if (bnd) begin
            case (state)
                LEADER: begin
                    if (run_cnt != '0) begin
                        enc_start = 1'b1;
                        run_nx    = run_cnt - 1'b1;
                    end else begin
                        state_nx    = BYTE;
                        frame_start = 1'b1;
                    end
                end
                BYTE: begin
                    if (bit_cnt != 4'd0) begin
                        enc_start = 1'b1;
                        enc_bit   = frame_sr[9];
                        frame_nx  = {frame_sr[8:0], 1'b0};
                        bit_nx    = bit_cnt - 4'd1;
                    end else if (bytes_sent == len_q) begin
                        state_nx  = TAIL;
                        enc_start = 1'b1;
                        run_nx    = RUN_W'(TAIL_BITS - 1);
                    end else begin
                        frame_start = 1'b1;
                    end
                end
                TAIL: begin
                    if (run_cnt != '0) begin
                        enc_start = 1'b1;
                        run_nx    = run_cnt - 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                default: ;
            endcase
            // The start bit goes out now; the rest of the frame waits in frame_sr.
            if (frame_start) begin
                enc_start = 1'b1;
                enc_bit   = 1'b0;
                frame_nx  = {hold, 2'b11};
                bit_nx    = 4'(FRAME_BITS - 1);
                sent_nx   = bytes_sent + AW'(1);
                consume   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            run_cnt    <= '0;
            bit_cnt    <= 4'd0;
            frame_sr   <= 10'd0;
            bytes_sent <= '0;
        end else begin
            state      <= state_nx;
            run_cnt    <= run_nx;
            bit_cnt    <= bit_nx;
            frame_sr   <= frame_nx;
            bytes_sent <= sent_nx;
        end
    end

    // RAM registers its address, so data is taken two clocks after addr moves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram.addr   <= '0;
            len_q      <= '0;
            hold       <= 8'd0;
            hold_valid <= 1'b0;
            fetch_pipe <= 2'b00;
            inc_pend   <= 1'b0;
        end else if (restart) begin
            ram.addr   <= '0;
            len_q      <= length;
            hold_valid <= 1'b0;
            fetch_pipe <= 2'b01;
            inc_pend   <= 1'b0;
        end else begin
            fetch_pipe <= {fetch_pipe[0], 1'b0};
            if (fetch_pipe[1] && !hold_valid) begin
                hold       <= ram.data;
                hold_valid <= 1'b1;
            end
            if (consume) begin
                hold_valid <= 1'b0;
                inc_pend   <= 1'b1;
            end
            if (inc_pend) begin
                inc_pend <= 1'b0;
                if (ram.addr != len_q - AW'(1)) begin
                    ram.addr   <= ram.addr + AW'(1);
                    fetch_pipe <= 2'b01;
                end
            end
        end
    end

endmodule

// File: tb/tb_caq_tape_player.sv
// Bench for caq_tape_player: the expected waveform is built per tick from the
// bit/frame encoding and compared tick by tick, with randomised ce_tape spacing.
module tb_caq_tape_player;

    localparam int AW = 8;
    localparam int LB = 4;
    localparam int TB = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ce_tape = 1'b0;
    logic          loaded = 1'b0;
    logic [AW-1:0] length = '0;
    logic          req;
    logic          out_lvl;
    logic [7:0]    mem [0:255];

    int checks = 0;
    int errors = 0;
    int max_addr = 0;
    bit exp_q[$];

    caq_tape_player_if #(.AW(AW)) ram_bus();

    caq_tape_player #(.AW(AW), .LEADER_BITS(LB), .TAIL_BITS(TB)) dut (
        .clk     (clk),
        .reset   (reset),
        .ce_tape (ce_tape),
        .loaded  (loaded),
        .length  (length),
        .ram     (ram_bus),
        .req     (req),
        .out     (out_lvl)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_bus.data <= mem[ram_bus.addr];

    typedef struct {
        int         len;
        logic [7:0] b0, b1, b2;
        int         exp_ticks;
        int         exp_max;
    } vec_t;

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (int'(ram_bus.addr) > max_addr) max_addr = int'(ram_bus.addr);
    endtask

    task automatic push_bit(input bit v);
        int n;
        n = v ? 1 : 2;
        repeat (n) exp_q.push_back(1'b1);
        repeat (n) exp_q.push_back(1'b0);
    endtask

    task automatic build_model(input int len);
        exp_q.delete();
        repeat (LB) push_bit(1'b1);
        for (int i = 0; i < len; i++) begin
            push_bit(1'b0);
            for (int b = 7; b >= 0; b--) push_bit(mem[i][b]);
            push_bit(1'b1);
            push_bit(1'b1);
        end
        repeat (TB) push_bit(1'b1);
    endtask

    // action: 0 none, 1 stop early (for a restart), 2 freeze ce_tape, 3 async reset
    task automatic run_play(input int len, input bit ce_on_load, input int action,
                            input int act_at, output int ticks);
        int idx;
        bit done;
        int lvl;
        int a;
        build_model(len);
        length  = AW'(len);
        loaded  = 1'b1;
        ce_tape = ce_on_load;
        step();
        loaded  = 1'b0;
        ce_tape = 1'b0;
        check("req_rise", req, 1);
        check("addr_start", ram_bus.addr, 0);
        max_addr = 0;
        idx = 0;
        done = 1'b0;
        ticks = 0;
        for (int g = 0; g < 4000 && !done; g++) begin
            repeat ($urandom_range(0, 2)) step();
            if (action == 2 && idx == act_at) begin
                lvl = out_lvl;
                a = ram_bus.addr;
                repeat (1000) step();
                check("freeze_out", out_lvl, lvl);
                check("freeze_req", req, 1);
                check("freeze_addr", ram_bus.addr, a);
            end
            if (action == 1 && idx == act_at) begin
                ticks = idx;
                return;
            end
            if (action == 3 && idx == act_at) begin
                ce_tape = 1'b1;
                #2 reset = 1'b1;
                #1;
                check("rst_out", out_lvl, 0);
                check("rst_req", req, 0);
                check("rst_addr", ram_bus.addr, 0);
                step();
                step();
                reset = 1'b0;
                ce_tape = 1'b0;
                ticks = idx;
                return;
            end
            ce_tape = 1'b1;
            step();
            ce_tape = 1'b0;
            if (req) begin
                if (idx < exp_q.size()) check("wave", out_lvl, exp_q[idx]);
                idx++;
            end else begin
                check("end_out", out_lvl, 0);
                check("req_fall_tick", idx, exp_q.size());
                done = 1'b1;
            end
        end
        if (!done) check("timeout", idx, exp_q.size());
        ticks = idx;
    endtask

    initial begin
        vec_t vecs[5];
        int t;
        int len;
        vecs[0] = '{1, 8'hA5, 8'h00, 8'h00,  44, 0};
        vecs[1] = '{3, 8'h00, 8'hFF, 8'h3C, 108, 2};
        vecs[2] = '{2, 8'h80, 8'h01, 8'h00,  88, 1};
        vecs[3] = '{1, 8'hFF, 8'h00, 8'h00,  36, 0};
        vecs[4] = '{1, 8'h00, 8'h00, 8'h00,  52, 0};
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        step();
        step();
        reset = 1'b0;
        step();
        check("reset_req", req, 0);
        check("reset_out", out_lvl, 0);
        check("reset_addr", ram_bus.addr, 0);

        // Zero-length image must not start playback.
        length  = '0;
        loaded  = 1'b1;
        ce_tape = 1'b1;
        step();
        loaded = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ce_tape = 1'($urandom_range(0, 1));
            step();
            check("len0_req", req, 0);
            check("len0_out", out_lvl, 0);
            check("len0_addr", ram_bus.addr, 0);
        end
        ce_tape = 1'b0;

        for (int v = 0; v < 5; v++) begin
            mem[0] = vecs[v].b0;
            mem[1] = vecs[v].b1;
            mem[2] = vecs[v].b2;
            run_play(vecs[v].len, 1'b0, 0, 0, t);
            check("total_ticks", t, vecs[v].exp_ticks);
            check("max_addr", max_addr, vecs[v].exp_max);
        end

        // Restart in the second frame, with ce_tape coincident on the loaded pulse.
        mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h3C;
        run_play(3, 1'b0, 1, 53, t);
        check("pre_restart_addr", ram_bus.addr, 2);
        run_play(2, 1'b1, 0, 0, t);
        check("restart_ticks", t, 76);
        check("restart_max_addr", max_addr, 1);

        mem[0] = 8'hA5;
        run_play(1, 1'b0, 2, 10, t);
        check("freeze_ticks", t, 44);

        mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h3C;
        run_play(3, 1'b0, 3, 55, t);
        mem[0] = 8'hA5;
        run_play(1, 1'b0, 0, 0, t);
        check("post_reset_ticks", t, 44);

        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) mem[i] = 8'($urandom);
            run_play(len, 1'($urandom_range(0, 1)), 0, 0, t);
            check("rand_max_addr", max_addr, len - 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
